// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : opcode/funct encodings, FSM states and ALU operations
// Rev 1.0
// ============================================================================
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH_LO  = 3'd0,
    FETCH_HI  = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM_LO    = 3'd4,
    MEM_HI    = 3'd5,
    WRITEBACK = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  function automatic logic [31:0] alu_calc(input alu_op_t op,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
    logic [31:0] r;
    case (op)
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_SLT: r = {31'd0, ($signed(x) < $signed(y))};
      default: r = x + y;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// ============================================================================
// mips_regfile : 32x32 GPRs, two async read ports, one sync write port
// Rev 1.0
// ============================================================================
module mips_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rd_addr_a,
  output logic [31:0] rd_data_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_b,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // $0 is hardwired on the read side as well, so it can never leak a value
  assign rd_data_a = (rd_addr_a == 5'd0) ? 32'd0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 5'd0) ? 32'd0 : regs[rd_addr_b];

endmodule
`default_nettype wire

// File: rtl/mips_core.sv
`default_nettype none
// ============================================================================
// mips_core : multicycle MIPS-subset CPU on a shared 16-bit async SRAM port
// Rev 1.0
// ============================================================================
module mips_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [17:0] addr,
  inout  wire  [15:0] data,
  output logic        wre,
  output logic        oute,
  output logic        hb_mask,
  output logic        lb_mask,
  output logic        chip_en
);

  state_t      state, next_state;
  logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic        is_rtype, is_addi, is_lw, is_sw, is_beq, is_j;
  alu_op_t     alu_op;
  logic [31:0] alu_b;

  logic [31:0] rs_val, rt_val;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic        bus_drive;
  logic [15:0] wr_half;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};

  assign is_addi = (opcode == OP_ADDI);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);

  // R-type with an unsupported funct is treated as a NOP
  always_comb begin
    is_rtype = 1'b0;
    alu_op   = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      is_rtype = 1'b1;
      case (funct)
        FN_ADD:  alu_op = ALU_ADD;
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: is_rtype = 1'b0;
      endcase
    end
  end

  assign alu_b = is_rtype ? b_reg : imm_sext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FETCH_LO;
    else       state <= next_state;
  end

  always_comb begin
    next_state = FETCH_LO;
    case (state)
      FETCH_LO:  next_state = FETCH_HI;
      FETCH_HI:  next_state = DECODE;
      DECODE:    next_state = (is_rtype || is_addi || is_lw || is_sw || is_beq)
                              ? EXECUTE : FETCH_LO;
      EXECUTE:   next_state = (is_lw || is_sw) ? MEM_LO
                            : is_beq           ? FETCH_LO : WRITEBACK;
      MEM_LO:    next_state = MEM_HI;
      MEM_HI:    next_state = is_lw ? WRITEBACK : FETCH_LO;
      WRITEBACK: next_state = FETCH_LO;
      default:   next_state = FETCH_LO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        FETCH_LO: ir[15:0] <= data;
        FETCH_HI: begin
          ir[31:16] <= data;
          pc        <= pc + 32'd4;
        end
        DECODE: begin
          a_reg <= rs_val;
          b_reg <= rt_val;
          if (is_j) pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        EXECUTE: begin
          alu_out <= alu_calc(alu_op, a_reg, alu_b);
          // pc already holds PC+4 here
          if (is_beq && (a_reg == b_reg)) pc <= pc + (imm_sext << 2);
        end
        MEM_LO: if (is_lw) mdr[15:0]  <= data;
        MEM_HI: if (is_lw) mdr[31:16] <= data;
        default: ;
      endcase
    end
  end

  assign rf_we    = (state == WRITEBACK) && (is_rtype || is_addi || is_lw);
  assign rf_waddr = is_rtype ? rd : rt;
  assign rf_wdata = is_lw ? mdr : alu_out;

  mips_regfile u_regfile (
    .clock     (clock),
    .reset     (reset),
    .rd_addr_a (rs),
    .rd_data_a (rs_val),
    .rd_addr_b (rt),
    .rd_data_b (rt_val),
    .wr_en     (rf_we),
    .wr_addr   (rf_waddr),
    .wr_data   (rf_wdata)
  );

  // Bus strobes come from state and latched registers only; reset forces idle
  always_comb begin
    addr      = '0;
    chip_en   = 1'b1;
    oute      = 1'b1;
    wre       = 1'b1;
    hb_mask   = 1'b1;
    lb_mask   = 1'b1;
    bus_drive = 1'b0;
    wr_half   = '0;
    if (!reset) begin
      case (state)
        FETCH_LO, FETCH_HI: begin
          addr    = {pc[18:2], (state == FETCH_HI)};
          chip_en = 1'b0;
          oute    = 1'b0;
          hb_mask = 1'b0;
          lb_mask = 1'b0;
        end
        MEM_LO, MEM_HI: begin
          addr    = {alu_out[18:2], (state == MEM_HI)};
          chip_en = 1'b0;
          hb_mask = 1'b0;
          lb_mask = 1'b0;
          if (is_sw) begin
            wre       = 1'b0;
            bus_drive = 1'b1;
            wr_half   = (state == MEM_HI) ? b_reg[31:16] : b_reg[15:0];
          end else begin
            oute = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign data = bus_drive ? wr_half : 16'hzzzz;

endmodule
`default_nettype wire

// File: tb/tb_mips_core.sv
`default_nettype none
// ============================================================================
// tb_mips_core : directed self-checking bench with a 256Kx16 behavioural SRAM
// Rev 1.0
// ============================================================================
module tb_mips_core;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] addr;
  wire  [15:0] data;
  logic        wre, oute, hb_mask, lb_mask, chip_en;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:262143];
  logic        ld_en = 1'b0;
  logic [17:0] ld_addr = '0;
  logic [15:0] ld_data = '0;
  int          wr_count = 0;
  logic [17:0] wr_addr_log [0:7];
  logic [15:0] wr_data_log [0:7];

  always #5 clock = ~clock;

  mips_core #(.RESET_PC(32'h0000_0000)) dut (
    .clock   (clock),
    .reset   (reset),
    .addr    (addr),
    .data    (data),
    .wre     (wre),
    .oute    (oute),
    .hb_mask (hb_mask),
    .lb_mask (lb_mask),
    .chip_en (chip_en)
  );

  assign data = (!chip_en && !oute && wre) ? mem[addr] : 16'hzzzz;

  always @(posedge clock) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (!chip_en && !wre) begin
      if (!lb_mask) mem[addr][7:0]  <= data[7:0];
      if (!hb_mask) mem[addr][15:8] <= data[15:8];
      if (wr_count < 8) begin
        wr_addr_log[wr_count] <= addr;
        wr_data_log[wr_count] <= data;
      end
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_half(input logic [17:0] a, input logic [15:0] d);
    @(negedge clock);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] byte_addr, input logic [31:0] w);
    logic [17:0] ha;
    ha = {byte_addr[18:2], 1'b0};
    load_half(ha, w[15:0]);
    load_half(ha + 18'd1, w[31:16]);
  endtask

  // Called at a negedge inside FETCH_LO (or later, with start cycles already spent);
  // returns at the negedge of the next FETCH_LO with the instruction's clock count.
  task automatic exec(input int start, output int cyc);
    cyc = start;
    do begin
      @(negedge clock);
      cyc++;
    end while (dut.state !== FETCH_LO && cyc < 20);
  endtask

  initial begin
    int cyc;
    int wr_base;
    reset = 1'b1;

    load_word(32'h00, 32'h2001_0005); // addi $1,$0,5
    load_word(32'h04, 32'h2002_FFFD); // addi $2,$0,-3
    load_word(32'h08, 32'h0022_1820); // add  $3,$1,$2
    load_word(32'h0C, 32'h0041_202A); // slt  $4,$2,$1
    load_word(32'h10, 32'hAC03_0040); // sw   $3,0x40($0)
    load_word(32'h14, 32'h8C05_0040); // lw   $5,0x40($0)
    load_word(32'h18, 32'h1021_0002); // beq  $1,$1,+2 (taken)
    load_word(32'h1C, 32'h2006_0001); // skipped
    load_word(32'h20, 32'h2006_0001); // skipped
    load_word(32'h24, 32'h1022_0002); // beq  $1,$2,+2 (not taken)
    load_word(32'h28, 32'h0800_0004); // j    0x10
    load_half(18'h20, 16'hDEAD);
    load_half(18'h21, 16'hBEEF);

    @(negedge clock);
    check("reset_strobes", {27'd0, chip_en, wre, oute, hb_mask, lb_mask}, 32'h1F);
    check("reset_addr", {14'd0, addr}, 32'h0);
    check("reset_drive", {31'd0, dut.bus_drive}, 32'h0);

    reset = 1'b0;
    #1;
    check("fetch_lo_addr", {14'd0, addr}, 32'h0);
    check("fetch_lo_strobes", {29'd0, chip_en, oute, wre}, 32'h1);
    @(negedge clock);
    check("fetch_hi_addr", {14'd0, addr}, 32'h1);
    exec(1, cyc);
    check("addi1_cycles", cyc, 5);
    check("r1", dut.u_regfile.regs[1], 32'h0000_0005);
    exec(0, cyc);
    check("addi2_cycles", cyc, 5);
    check("r2", dut.u_regfile.regs[2], 32'hFFFF_FFFD);
    exec(0, cyc);
    check("add_cycles", cyc, 5);
    check("r3", dut.u_regfile.regs[3], 32'h0000_0002);
    exec(0, cyc);
    check("slt_cycles", cyc, 5);
    check("r4", dut.u_regfile.regs[4], 32'h0000_0001);

    wr_base = wr_count;
    exec(0, cyc);
    check("sw_cycles", cyc, 6);
    check("sw_write_count", wr_count - wr_base, 2);
    check("sw_lo_addr", {14'd0, wr_addr_log[wr_base]}, 32'h20);
    check("sw_lo_data", {16'd0, wr_data_log[wr_base]}, 32'h0002);
    check("sw_hi_addr", {14'd0, wr_addr_log[wr_base + 1]}, 32'h21);
    check("sw_hi_data", {16'd0, wr_data_log[wr_base + 1]}, 32'h0000);
    check("mem_0x40", {mem[18'h21], mem[18'h20]}, 32'h0000_0002);

    exec(0, cyc);
    check("lw_cycles", cyc, 7);
    check("r5", dut.u_regfile.regs[5], 32'h0000_0002);

    exec(0, cyc);
    check("beq_taken_cycles", cyc, 4);
    check("beq_taken_fetch", {14'd0, addr}, 32'h12);
    exec(0, cyc);
    check("beq_not_taken_cycles", cyc, 4);
    check("beq_not_taken_fetch", {14'd0, addr}, 32'h14);
    check("r6_skipped", dut.u_regfile.regs[6], 32'h0);

    exec(0, cyc);
    check("j_cycles", cyc, 3);
    check("j_fetch_addr", {14'd0, addr}, 32'h8);
    check("j_fetch_read", {30'd0, chip_en, oute}, 32'h0);

    // Second program: $0 protection, unknown opcode, reset during a store
    #1 reset = 1'b1;
    load_word(32'h00, 32'h2000_0007); // addi $0,$0,7
    load_word(32'h04, 32'hFC00_0000); // unknown opcode
    load_word(32'h08, 32'h2007_1234); // addi $7,$0,0x1234
    load_word(32'h0C, 32'hAC07_0080); // sw   $7,0x80($0)
    load_half(18'h40, 16'hAAAA);
    load_half(18'h41, 16'hBBBB);
    @(negedge clock);
    wr_base = wr_count;
    reset = 1'b0;

    exec(0, cyc);
    check("addi_r0_cycles", cyc, 5);
    check("r0_zero", dut.u_regfile.regs[0], 32'h0);
    exec(0, cyc);
    check("nop_cycles", cyc, 3);
    check("nop_next_fetch", {14'd0, addr}, 32'h4);
    exec(0, cyc);
    check("r7", dut.u_regfile.regs[7], 32'h0000_1234);

    repeat (4) @(negedge clock);
    check("mem_lo_state", {29'd0, dut.state}, {29'd0, MEM_LO});
    check("mem_lo_addr", {14'd0, addr}, 32'h40);
    check("mem_lo_wre", {31'd0, wre}, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("abort_strobes", {27'd0, chip_en, wre, oute, hb_mask, lb_mask}, 32'h1F);
    check("abort_drive", {31'd0, dut.bus_drive}, 32'h0);
    repeat (3) @(negedge clock);
    check("abort_writes", wr_count - wr_base, 0);
    check("abort_mem", {mem[18'h41], mem[18'h40]}, 32'hBBBB_AAAA);
    check("abort_pc", dut.pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
